// File: rtl/rom_prefetch.sv
// Sequential-address prefetch buffer sitting between a CPU fetch port and a
// single-outstanding-request ROM. Bytes are fetched ahead into a small FIFO;
// a CPU request at the head address hits combinationally, any other address
// flushes the FIFO and restarts prefetch from the requested address.
module rom_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic        cpu_valid,
  output logic [7:0]  cpu_data,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [3:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [3:0]    LVL_MAX = 4'(DEPTH);

  // DRAIN: a flush abandoned the outstanding request; wait out its ack with
  // the old address still on mem_addr, then restart at the new fetch address.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t          r_state;
  logic [7:0]      r_buf [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [3:0]      r_level;
  logic [11:0]     r_fetch_addr;
  logic [11:0]     r_mem_addr;
  logic            r_mem_req;

  logic [11:0]     w_head_addr;
  logic            w_flush;
  logic            w_hit;
  logic            w_take;
  logic            w_wr;
  logic [3:0]      w_level_nxt;
  logic [11:0]     w_fetch_nxt;
  logic            w_room;

  // The fetch address only advances on ack, so the head is always
  // fetch_addr - level; an empty buffer puts the head at fetch_addr.
  assign w_head_addr = r_fetch_addr - {8'd0, r_level};
  // Any request not at the head is a miss; a request at fetch_addr with an
  // empty buffer matches the head and simply waits.
  assign w_flush     = cpu_req & (cpu_addr != w_head_addr);
  assign w_hit       = cpu_req & (r_level != 4'd0) & ~w_flush;
  // Ack only completes a live fetch; acks in IDLE or DRAIN carry no data for us.
  assign w_take      = (r_state == S_FETCH) & mem_ack;
  assign w_wr        = w_take & ~w_flush;
  assign w_level_nxt = w_flush ? 4'd0 : (r_level + {3'd0, w_wr} - {3'd0, w_hit});
  assign w_fetch_nxt = w_flush ? cpu_addr : (w_take ? r_fetch_addr + 12'd1 : r_fetch_addr);
  assign w_room      = (w_level_nxt < LVL_MAX);

  assign cpu_valid = w_hit;
  assign cpu_data  = r_buf[r_rd_ptr];
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign level     = r_level;

  // Occupancy, pointers and the fetch address; a flush empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level      <= 4'd0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fetch_addr <= 12'h000;
    end else begin
      r_level      <= w_level_nxt;
      r_fetch_addr <= w_fetch_nxt;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_hit) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Buffer storage: write the acked byte at the tail.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wr_ptr] <= mem_data;
  end

  // Request FSM; mem_req/mem_addr are registered and mem_addr only moves
  // when no request is outstanding (entering FETCH, or on ack).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush | w_room) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_fetch_nxt;
          end
        end
        S_FETCH: begin
          if (w_flush & ~mem_ack) begin
            r_state <= S_DRAIN;
          end else if (mem_ack) begin
            if (w_flush | w_room) begin
              r_mem_addr <= w_fetch_nxt;
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            r_state    <= S_FETCH;
            r_mem_addr <= w_fetch_nxt;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_prefetch.sv
// Directed bench for rom_prefetch: reset, reset-vector fill, streaming,
// spurious ack, jump, flush during an outstanding request, wrap, mid-fetch reset.
module tb_rom_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic        cpu_valid;
  logic [7:0]  cpu_data;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;
  int lat = 2;
  int cnt = 0;
  bit spurious = 1'b0;
  int w;
  logic [7:0] d;

  rom_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [11:0] a);
    return a[7:0] ^ a[11:4] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ROM: acks on the lat-th cycle a request has been held; spurious forces an ack.
  always @(negedge clk) begin
    if (spurious) begin
      mem_ack  = 1'b1;
      mem_data = 8'hEE;
    end else if (mem_req && !rst) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack  = 1'b1;
        mem_data = rom(mem_addr);
        cnt      = 0;
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      cnt     = 0;
      mem_ack = 1'b0;
    end
  end

  // Hold a request until it hits (bounded), return cycles waited and data.
  task automatic cpu_get(input logic [11:0] a, output int waited, output logic [7:0] dat);
    cpu_req  = 1'b1;
    cpu_addr = a;
    waited   = 0;
    #1;
    while (!cpu_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!cpu_valid) chk("get_timeout", 32'(a), 32'hFFFF);
    dat = cpu_data;
    tick();
  endtask

  // Reset, reset-vector fill at latency 2, stream 0x000..0x00F at latency 1,
  // then idle so the buffer holds 0x010..0x013.
  task automatic prep(input bit do_chk);
    int nreq;
    logic [11:0] la [4];
    logic [11:0] last;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = 12'h000; lat = 2;
    repeat (2) tick();
    if (do_chk) begin
      cpu_req = 1'b1; #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_level", level, 0);
      chk("rst_cpu_valid", cpu_valid, 0);
      cpu_req = 1'b0;
    end
    rst = 1'b0;
    tick();
    if (do_chk) begin
      chk("rstvec_req", mem_req, 1);
      chk("rstvec_addr", mem_addr, 0);
    end
    nreq = 1; la[0] = mem_addr; last = mem_addr;
    repeat (13) begin
      tick();
      if (mem_req && mem_addr != last) begin
        if (nreq < 4) la[nreq] = mem_addr;
        nreq++;
        last = mem_addr;
      end
    end
    if (do_chk) begin
      chk("fill_nreq", nreq, 4);
      for (int i = 1; i < 4; i++) chk("fill_addr", la[i], i);
      chk("fill_level", level, 4);
      chk("fill_req_off", mem_req, 0);
    end
    lat = 1;
    for (int a = 0; a < 16; a++) begin
      cpu_get(12'(a), w, d);
      if (do_chk) begin
        chk("stream_wait", w, 0);
        chk("stream_data", d, rom(12'(a)));
      end
    end
    if (do_chk) chk("stream_level", level, 3);
    cpu_req = 1'b0;
    repeat (8) tick();
    if (do_chk) begin
      chk("refill_level", level, 4);
      chk("refill_req_off", mem_req, 0);
      chk("refill_head", cpu_data, rom(12'h010));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    prep(1'b1);

    // Spurious ack while idle and full must be ignored.
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("idle_ack_level", level, 4);
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_head", cpu_data, rom(12'h010));

    // Jump from a full 0x010..0x013 buffer to 0x080.
    lat = 2;
    cpu_req = 1'b1; cpu_addr = 12'h080; #1;
    chk("jump_nohit", cpu_valid, 0);
    tick();
    chk("jump_level", level, 0);
    chk("jump_mem_addr", mem_addr, 12'h080);
    chk("jump_mem_req", mem_req, 1);
    cpu_get(12'h080, w, d);
    chk("jump_latency", w + 1, 3);
    chk("jump_data", d, rom(12'h080));
    cpu_req = 1'b0;

    // Flush while the 0x014 request is outstanding.
    prep(1'b0);
    lat = 4;
    cpu_get(12'h010, w, d);
    chk("pend_req", mem_req, 1);
    chk("pend_addr", mem_addr, 12'h014);
    cpu_req = 1'b1; cpu_addr = 12'h200; #1;
    chk("flush_nohit", cpu_valid, 0);
    tick();
    chk("drain_addr", mem_addr, 12'h014);
    chk("drain_req", mem_req, 1);
    chk("drain_level", level, 0);
    for (int k = 3; k <= 4; k++) begin
      tick();
      chk("drain_hold", mem_addr, 12'h014);
    end
    tick();
    chk("drain_next_addr", mem_addr, 12'h200);
    chk("drain_discard", level, 0);
    cpu_get(12'h200, w, d);
    chk("flush_wait", w, 4);
    chk("flush_data", d, rom(12'h200));

    // Stream across the 0xFFF -> 0x000 wrap.
    cpu_req = 1'b0; lat = 1;
    repeat (10) tick();
    cpu_get(12'hFFE, w, d);
    chk("wrap_first_wait", w, 2);
    chk("wrap_data_ffe", d, rom(12'hFFE));
    cpu_get(12'hFFF, w, d);
    chk("wrap_wait_fff", w, 0);
    chk("wrap_data_fff", d, rom(12'hFFF));
    cpu_get(12'h000, w, d);
    chk("wrap_wait_000", w, 0);
    chk("wrap_data_000", d, rom(12'h000));
    cpu_get(12'h001, w, d);
    chk("wrap_wait_001", w, 0);
    chk("wrap_data_001", d, rom(12'h001));

    // Reset while a request is outstanding.
    chk("pre_rst_req", mem_req, 1);
    cpu_req = 1'b0; lat = 3; rst = 1'b1;
    tick();
    chk("midrst_req", mem_req, 0);
    chk("midrst_level", level, 0);
    chk("midrst_addr", mem_addr, 0);
    rst = 1'b0;
    tick();
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 0);
    cpu_get(12'h000, w, d);
    chk("restart_wait", w, 3);
    chk("restart_data", d, rom(12'h000));
    cpu_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
